inferno_stick_8way: RTL and testbench

Converts the MiSTer analog stick words for one Inferno player into the two 8-way direction nibbles (run, aim) consumed by the `williams2` core's `btn_run_*` / `btn_aim_*` inputs. It sits between `hps_io` and `williams2` in the `emu` top and replaces the raw analog pass-through. Each stick gets:
- a deadzone with hysteresis,
- an 8-sector decode,
- a sample-count debounce.

The run path also has a digital D-pad override.

---
 rtl/inferno_stick_8way.sv | 261 ++++++++++++++++++++++++++
 tb/tb_inferno_stick_8way.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inferno_stick_8way.sv
// ---------------------------------------------------------------------------
// inferno_stick_8way
//
// Turns one Inferno player's MiSTer analog stick words into the two 8-way
// direction nibbles (run, aim) that williams2 expects on btn_run_* and
// btn_aim_*. Each stick goes through a deadzone with hysteresis, an 8-sector
// decode and a sample-count debounce. The run path also takes a D-pad
// override.
//
// Pipeline: S0 captures the inputs on sample_ce. S1 updates the per-axis
// active flags and forms a candidate direction. S2 debounces the candidate
// into the output registers. A sample_ce in cycle N shows up on the outputs
// in cycle N+3.
//
// Ports
//   clk_sys      in   system clock
//   reset_n      in   asynchronous active-low reset
//   sample_ce    in   one-cycle sample strobe
//   run_analog   in   [7:0] X signed (neg = left), [15:8] Y signed (neg = up)
//   aim_analog   in   right stick, same format
//   run_digital  in   D-pad {up,down,left,right}
//   run_dir      out  debounced run direction {up,down,left,right}
//   aim_dir      out  debounced aim direction, same encoding
//   dir_changed  out  one-cycle pulse when either direction output changes
// ---------------------------------------------------------------------------
module inferno_stick_8way #(
    parameter logic [7:0] DEADZONE = 8'd32,
    parameter logic [7:0] HYST     = 8'd8,
    parameter logic [1:0] HOLD     = 2'd3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        sample_ce,
    input  logic [15:0] run_analog,
    input  logic [15:0] aim_analog,
    input  logic [3:0]  run_digital,
    output logic [3:0]  run_dir,
    output logic [3:0]  aim_dir,
    output logic        dir_changed
);

    localparam logic [8:0] ON_THR  = {1'b0, DEADZONE} + {1'b0, HYST};
    localparam logic [8:0] OFF_THR = {1'b0, DEADZONE};

    // Saturating absolute value: -128 maps to 127 rather than wrapping to 0.
    function automatic logic [8:0] mag9(input logic [7:0] v);
        logic [6:0] r;
        if (!v[7]) begin
            r = v[6:0];
        end else if (v == 8'h80) begin
            r = 7'd127;
        end else begin
            // Low 7 bits of the two's-complement negation.
            r = ~v[6:0] + 7'd1;
        end
        return {2'b00, r};
    endfunction

    // An idle axis needs DEADZONE+HYST to wake up; an active one only drops
    // out below DEADZONE, so a stick resting near the edge does not chatter.
    function automatic logic axis_next(input logic cur, input logic [8:0] m);
        logic nxt;
        if (!cur) begin
            nxt = (m >= ON_THR);
        end else begin
            nxt = (m >= OFF_THR);
        end
        return nxt;
    endfunction

    // 8-sector decode. With both axes active the larger magnitude is the
    // major axis (X on a tie); the minor one is only kept when it is at least
    // half the major, which splits the plane into 45-degree-ish sectors.
    function automatic logic [3:0] decode(
        input logic       ax,
        input logic       ay,
        input logic [8:0] mx,
        input logic [8:0] my,
        input logic       sx,
        input logic       sy
    );
        logic [3:0] xb;
        logic [3:0] yb;
        logic [8:0] maj;
        logic [8:0] mnr;
        logic [3:0] d;
        xb  = sx ? 4'b0010 : 4'b0001;
        yb  = sy ? 4'b1000 : 4'b0100;
        maj = 9'd0;
        mnr = 9'd0;
        d   = 4'b0000;
        if (ax && ay) begin
            if (mx >= my) begin
                maj = mx;
                mnr = my;
            end else begin
                maj = my;
                mnr = mx;
            end
            if ({mnr[7:0], 1'b0} >= maj) begin
                d = xb | yb;
            end else if (mx >= my) begin
                d = xb;
            end else begin
                d = yb;
            end
        end else if (ax) begin
            d = xb;
        end else if (ay) begin
            d = yb;
        end
        return d;
    endfunction

    // Returns {out, last, count}. A forced sample (D-pad) skips the hold
    // wait and leaves the debouncer settled on the forced value.
    function automatic logic [9:0] debounce(
        input logic [3:0] cand,
        input logic       force_en,
        input logic [3:0] last,
        input logic [1:0] cnt,
        input logic [3:0] out
    );
        logic [3:0] nl;
        logic [1:0] nc;
        logic [3:0] no;
        if (force_en) begin
            nl = cand;
            nc = HOLD;
            no = cand;
        end else begin
            if (cand != last) begin
                nl = cand;
                nc = 2'd1;
            end else begin
                nl = last;
                nc = (cnt >= HOLD) ? HOLD : cnt + 2'd1;
            end
            no = ((nc == HOLD) && (nl != out)) ? nl : out;
        end
        return {no, nl, nc};
    endfunction

    // S0 capture
    logic        s0_vld_q;
    logic [15:0] s0_run_q;
    logic [15:0] s0_aim_q;
    logic [3:0]  s0_dig_q;

    // S1 axis state and candidates
    logic        run_ax_x_q, run_ax_y_q, aim_ax_x_q, aim_ax_y_q;
    logic        run_ax_x_d, run_ax_y_d, aim_ax_x_d, aim_ax_y_d;
    logic        s1_vld_q;
    logic [3:0]  s1_run_cand_q, s1_aim_cand_q;
    logic [3:0]  s1_run_cand_d, s1_aim_cand_d;
    logic        s1_run_force_q, s1_run_force_d;

    // S2 debounce and outputs
    logic [3:0]  run_last_q, aim_last_q, run_last_d, aim_last_d;
    logic [1:0]  run_cnt_q, aim_cnt_q, run_cnt_d, aim_cnt_d;
    logic [3:0]  run_dir_q, aim_dir_q, run_dir_d, aim_dir_d;
    logic        dir_changed_q, dir_changed_d;

    logic [8:0]  run_mx, run_my, aim_mx, aim_my;
    logic [3:0]  run_cand_a;
    logic [3:0]  dig_clean;

    always_comb begin
        run_mx = mag9(s0_run_q[7:0]);
        run_my = mag9(s0_run_q[15:8]);
        aim_mx = mag9(s0_aim_q[7:0]);
        aim_my = mag9(s0_aim_q[15:8]);

        run_ax_x_d = axis_next(run_ax_x_q, run_mx);
        run_ax_y_d = axis_next(run_ax_y_q, run_my);
        aim_ax_x_d = axis_next(aim_ax_x_q, aim_mx);
        aim_ax_y_d = axis_next(aim_ax_y_q, aim_my);

        run_cand_a = decode(run_ax_x_d, run_ax_y_d, run_mx, run_my,
                            s0_run_q[7], s0_run_q[15]);
        s1_aim_cand_d = decode(aim_ax_x_d, aim_ax_y_d, aim_mx, aim_my,
                               s0_aim_q[7], s0_aim_q[15]);

        // Opposing D-pad directions cancel each other.
        dig_clean = s0_dig_q;
        if (s0_dig_q[3] && s0_dig_q[2]) begin
            dig_clean[3:2] = 2'b00;
        end
        if (s0_dig_q[1] && s0_dig_q[0]) begin
            dig_clean[1:0] = 2'b00;
        end
        s1_run_force_d = |dig_clean;
        s1_run_cand_d  = s1_run_force_d ? dig_clean : run_cand_a;

        {run_dir_d, run_last_d, run_cnt_d} =
            debounce(s1_run_cand_q, s1_run_force_q, run_last_q, run_cnt_q, run_dir_q);
        {aim_dir_d, aim_last_d, aim_cnt_d} =
            debounce(s1_aim_cand_q, 1'b0, aim_last_q, aim_cnt_q, aim_dir_q);

        dir_changed_d = s1_vld_q &&
                        ((run_dir_d != run_dir_q) || (aim_dir_d != aim_dir_q));
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s0_vld_q       <= 1'b0;
            s0_run_q       <= 16'd0;
            s0_aim_q       <= 16'd0;
            s0_dig_q       <= 4'd0;
            run_ax_x_q     <= 1'b0;
            run_ax_y_q     <= 1'b0;
            aim_ax_x_q     <= 1'b0;
            aim_ax_y_q     <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_run_cand_q  <= 4'd0;
            s1_aim_cand_q  <= 4'd0;
            s1_run_force_q <= 1'b0;
            run_last_q     <= 4'd0;
            aim_last_q     <= 4'd0;
            run_cnt_q      <= 2'd0;
            aim_cnt_q      <= 2'd0;
            run_dir_q      <= 4'd0;
            aim_dir_q      <= 4'd0;
            dir_changed_q  <= 1'b0;
        end else begin
            s0_vld_q <= sample_ce;
            if (sample_ce) begin
                s0_run_q <= run_analog;
                s0_aim_q <= aim_analog;
                s0_dig_q <= run_digital;
            end

            s1_vld_q <= s0_vld_q;
            if (s0_vld_q) begin
                run_ax_x_q     <= run_ax_x_d;
                run_ax_y_q     <= run_ax_y_d;
                aim_ax_x_q     <= aim_ax_x_d;
                aim_ax_y_q     <= aim_ax_y_d;
                s1_run_cand_q  <= s1_run_cand_d;
                s1_aim_cand_q  <= s1_aim_cand_d;
                s1_run_force_q <= s1_run_force_d;
            end

            if (s1_vld_q) begin
                run_last_q <= run_last_d;
                aim_last_q <= aim_last_d;
                run_cnt_q  <= run_cnt_d;
                aim_cnt_q  <= aim_cnt_d;
                run_dir_q  <= run_dir_d;
                aim_dir_q  <= aim_dir_d;
            end

            dir_changed_q <= dir_changed_d;
        end
    end

    assign run_dir     = run_dir_q;
    assign aim_dir     = aim_dir_q;
    assign dir_changed = dir_changed_q;

endmodule

// File: tb/tb_inferno_stick_8way.sv
// Directed bench for inferno_stick_8way with default parameters
// (DEADZONE=32, HYST=8, HOLD=3). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_inferno_stick_8way;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        sample_ce;
    logic [15:0] run_analog;
    logic [15:0] aim_analog;
    logic [3:0]  run_digital;
    logic [3:0]  run_dir;
    logic [3:0]  aim_dir;
    logic        dir_changed;

    int total = 0;
    int bad   = 0;

    always #5 clk_sys = ~clk_sys;

    inferno_stick_8way dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .sample_ce   (sample_ce),
        .run_analog  (run_analog),
        .aim_analog  (aim_analog),
        .run_digital (run_digital),
        .run_dir     (run_dir),
        .aim_dir     (aim_dir),
        .dir_changed (dir_changed)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n back-to-back samples of one input set; returns in cycle N+3 of the
    // last sample. Inputs are scrambled afterwards since they are not captured.
    task automatic burst(input logic [7:0] rx, input logic [7:0] ry,
                         input logic [7:0] ax, input logic [7:0] ay,
                         input logic [3:0] dig, input int n);
        run_analog  = {ry, rx};
        aim_analog  = {ay, ax};
        run_digital = dig;
        sample_ce   = 1'b1;
        repeat (n) @(negedge clk_sys);
        sample_ce   = 1'b0;
        run_analog  = 16'h8080;
        aim_analog  = 16'h7F7F;
        run_digital = 4'b0001;
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b1;
        sample_ce   = 1'b0;
        run_analog  = 16'h0;
        aim_analog  = 16'h0;
        run_digital = 4'h0;
        #1 reset_n  = 1'b0;
        #1;
        check_val("rst_run", {4'h0, run_dir}, 8'h00);
        check_val("rst_aim", {4'h0, aim_dir}, 8'h00);
        check_val("rst_dc",  {7'h0, dir_changed}, 8'h00);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Cardinal: two samples are not enough, the third commits.
        burst(8'h64, 8'h00, 8'h00, 8'h00, 4'h0, 2);
        check_val("card_2pulses", {4'h0, run_dir}, 8'h00);
        burst(8'h64, 8'h00, 8'h00, 8'h00, 4'h0, 1);
        check_val("card_run", {4'h0, run_dir}, 8'h01);
        check_val("card_dc", {7'h0, dir_changed}, 8'h01);
        check_val("card_aim", {4'h0, aim_dir}, 8'h00);
        @(negedge clk_sys);
        check_val("card_dc_end", {7'h0, dir_changed}, 8'h00);
        check_val("card_hold", {4'h0, run_dir}, 8'h01);
        burst(8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 3);
        check_val("card_release", {4'h0, run_dir}, 8'h00);

        // Hysteresis on aim X.
        burst(8'h00, 8'h00, 8'h26, 8'h00, 4'h0, 3);
        check_val("hyst_38", {4'h0, aim_dir}, 8'h00);
        burst(8'h00, 8'h00, 8'h32, 8'h00, 4'h0, 3);
        check_val("hyst_50", {4'h0, aim_dir}, 8'h01);
        check_val("hyst_50_dc", {7'h0, dir_changed}, 8'h01);
        burst(8'h00, 8'h00, 8'h23, 8'h00, 4'h0, 3);
        check_val("hyst_35", {4'h0, aim_dir}, 8'h01);
        check_val("hyst_35_dc", {7'h0, dir_changed}, 8'h00);
        burst(8'h00, 8'h00, 8'h1F, 8'h00, 4'h0, 3);
        check_val("hyst_31", {4'h0, aim_dir}, 8'h00);

        // Sector decode on run.
        burst(8'h64, 8'hC4, 8'h00, 8'h00, 4'h0, 3);
        check_val("diag_100_m60", {4'h0, run_dir}, 8'h09);
        burst(8'h64, 8'hD3, 8'h00, 8'h00, 4'h0, 3);
        check_val("diag_100_m45", {4'h0, run_dir}, 8'h01);
        burst(8'h80, 8'h00, 8'h00, 8'h00, 4'h0, 3);
        check_val("sat_m128", {4'h0, run_dir}, 8'h02);

        // D-pad override.
        burst(8'h64, 8'h00, 8'h00, 8'h00, 4'h0, 3);
        check_val("ovr_pre", {4'h0, run_dir}, 8'h01);
        burst(8'h64, 8'h00, 8'h00, 8'h00, 4'b1000, 1);
        check_val("ovr_up", {4'h0, run_dir}, 8'h08);
        check_val("ovr_up_dc", {7'h0, dir_changed}, 8'h01);
        burst(8'h64, 8'h00, 8'h00, 8'h00, 4'b1100, 1);
        check_val("ovr_ud_1", {4'h0, run_dir}, 8'h08);
        check_val("ovr_ud_1_dc", {7'h0, dir_changed}, 8'h00);
        burst(8'h64, 8'h00, 8'h00, 8'h00, 4'b1100, 2);
        check_val("ovr_ud_3", {4'h0, run_dir}, 8'h01);
        burst(8'h00, 8'h00, 8'h00, 8'h00, 4'b0011, 1);
        check_val("ovr_lr_1", {4'h0, run_dir}, 8'h01);
        burst(8'h00, 8'h00, 8'h00, 8'h00, 4'b0011, 2);
        check_val("ovr_lr_3", {4'h0, run_dir}, 8'h00);
        burst(8'h00, 8'h00, 8'h00, 8'h00, 4'b1001, 1);
        check_val("ovr_diag", {4'h0, run_dir}, 8'h09);

        // Run and aim change on the same sample.
        run_analog  = {8'h00, 8'h9C};
        aim_analog  = {8'h64, 8'h00};
        run_digital = 4'h0;
        sample_ce   = 1'b1;
        repeat (3) @(negedge clk_sys);
        sample_ce   = 1'b0;
        @(negedge clk_sys);
        check_val("sim_n2_run", {4'h0, run_dir}, 8'h09);
        check_val("sim_n2_aim", {4'h0, aim_dir}, 8'h00);
        check_val("sim_n2_dc", {7'h0, dir_changed}, 8'h00);
        @(negedge clk_sys);
        check_val("sim_run", {4'h0, run_dir}, 8'h02);
        check_val("sim_aim", {4'h0, aim_dir}, 8'h04);
        check_val("sim_dc", {7'h0, dir_changed}, 8'h01);
        @(negedge clk_sys);
        check_val("sim_dc_end", {7'h0, dir_changed}, 8'h00);

        // No sample strobes: everything holds whatever the inputs do.
        for (int i = 0; i < 20; i++) begin
            run_analog  = 16'(i * 16'h1357);
            aim_analog  = 16'(i * 16'h2468);
            run_digital = 4'(i);
            @(negedge clk_sys);
        end
        check_val("frz_run", {4'h0, run_dir}, 8'h02);
        check_val("frz_aim", {4'h0, aim_dir}, 8'h04);
        check_val("frz_dc", {7'h0, dir_changed}, 8'h00);

        // Reset in the middle of a sample stream.
        run_analog  = {8'h00, 8'h64};
        aim_analog  = {8'h00, 8'h9C};
        run_digital = 4'h0;
        sample_ce   = 1'b1;
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check_val("mrst_run", {4'h0, run_dir}, 8'h00);
        check_val("mrst_aim", {4'h0, aim_dir}, 8'h00);
        @(negedge clk_sys);
        sample_ce = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        check_val("mrst_flush_run", {4'h0, run_dir}, 8'h00);
        check_val("mrst_flush_aim", {4'h0, aim_dir}, 8'h00);
        check_val("mrst_flush_dc", {7'h0, dir_changed}, 8'h00);
        burst(8'h00, 8'h00, 8'h64, 8'h00, 4'h0, 2);
        check_val("mrst_2pulses", {4'h0, aim_dir}, 8'h00);
        burst(8'h00, 8'h00, 8'h64, 8'h00, 4'h0, 1);
        check_val("mrst_aim_on", {4'h0, aim_dir}, 8'h01);
        check_val("mrst_run_off", {4'h0, run_dir}, 8'h00);
        check_val("mrst_dc", {7'h0, dir_changed}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
